// File: rtl/rv_fetch_pkg.sv
// rv_fetch_pkg
//   Shared definitions for the fetch queue: the queue entry layout, the
//   default queue depth and a helper that classifies an instruction word
//   as compressed (RVC) or full-width.
package rv_fetch_pkg;

    localparam int FETCH_Q_DEPTH = 4;
    localparam int FETCH_XLEN    = 32;

    // One queued instruction together with the pc it was fetched from.
    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] instruction;
    } fetch_entry_t;

    // An RVC instruction is any encoding whose two low bits are not 2'b11.
    function automatic logic is_compressed(input logic [FETCH_XLEN-1:0] instr);
        return (instr[1:0] != 2'b11);
    endfunction

endpackage

// File: rtl/rv_fetch_queue_mem.sv
// rv_fetch_queue_mem
//   Entry storage for the fetch queue: DEPTH x fetch_entry_t, one
//   synchronous write port and one asynchronous read port. The array is not
//   reset; the control logic never exposes an unwritten slot.
// Ports:
//   i_clk      clock
//   i_wr_en    write strobe
//   i_wr_addr  write slot index
//   i_wr_data  entry to store
//   i_rd_addr  read slot index
//   o_rd_data  entry at i_rd_addr (combinational)
module rv_fetch_queue_mem
    import rv_fetch_pkg::*;
#(
    parameter int DEPTH = FETCH_Q_DEPTH
) (
    input  logic                     i_clk,
    input  logic                     i_wr_en,
    input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
    input  fetch_entry_t             i_wr_data,
    input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
    output fetch_entry_t             o_rd_data
);

    fetch_entry_t mem_r [DEPTH];

    // Write port: store the incoming entry at the write slot.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            mem_r[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = mem_r[i_rd_addr];

endmodule

// File: rtl/rv_fetch_queue.sv
// rv_fetch_queue
//   Instruction fetch queue between the aligner and decode. Entries are
//   pushed from the aligner and popped by decode in order. A redirect
//   (i_flush) empties the queue; pushes while full are dropped and flagged
//   on the sticky o_overflow. There is no bypass: a pushed entry reaches the
//   head one cycle after the push.
//   XLEN must equal rv_fetch_pkg::FETCH_XLEN since entries use fetch_entry_t.
// Ports:
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_flush               redirect, discard every queued entry
//   i_valid/i_pc/i_instruction/o_in_ready   push side (aligner)
//   o_valid/o_pc/o_instruction/o_compressed/i_ready   pop side (decode)
//   o_count               occupancy
//   o_overflow            sticky: push attempted while full
module rv_fetch_queue
    import rv_fetch_pkg::*;
#(
    parameter int DEPTH = FETCH_Q_DEPTH,
    parameter int XLEN  = FETCH_XLEN
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_flush,
    input  logic                     i_valid,
    input  logic [XLEN-1:0]          i_pc,
    input  logic [XLEN-1:0]          i_instruction,
    output logic                     o_in_ready,
    output logic                     o_valid,
    output logic [XLEN-1:0]          o_pc,
    output logic [XLEN-1:0]          o_instruction,
    output logic                     o_compressed,
    input  logic                     i_ready,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          overflow_r;

    logic          in_ready_s;
    logic          valid_s;
    logic          push_s;
    logic          pop_s;
    logic          drop_s;
    fetch_entry_t  wr_entry_s;
    fetch_entry_t  rd_entry_s;

    // Handshake flags depend only on registered occupancy, so there is no
    // combinational path from i_ready to o_in_ready.
    assign in_ready_s = (count_r != FULL_COUNT);
    assign valid_s    = (count_r != {CW{1'b0}});
    assign push_s     = i_valid & in_ready_s & ~i_flush;
    assign pop_s      = valid_s & i_ready & ~i_flush;
    assign drop_s     = i_valid & ~in_ready_s & ~i_flush;

    assign wr_entry_s.pc          = i_pc;
    assign wr_entry_s.instruction = i_instruction;

    rv_fetch_queue_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .i_clk     (i_clk),
        .i_wr_en   (push_s),
        .i_wr_addr (wr_ptr_r),
        .i_wr_data (wr_entry_s),
        .i_rd_addr (rd_ptr_r),
        .o_rd_data (rd_entry_s)
    );

    // Queue control: reset beats flush, flush beats push/pop. Pointers wrap
    // naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) begin
            wr_ptr_r   <= {PW{1'b0}};
            rd_ptr_r   <= {PW{1'b0}};
            count_r    <= {CW{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Head fields read as zero whenever the queue is empty so stale storage
    // never leaks toward decode.
    assign o_in_ready    = in_ready_s;
    assign o_valid       = valid_s;
    assign o_pc          = valid_s ? rd_entry_s.pc : {XLEN{1'b0}};
    assign o_instruction = valid_s ? rd_entry_s.instruction : {XLEN{1'b0}};
    assign o_compressed  = valid_s ? is_compressed(rd_entry_s.instruction) : 1'b0;
    assign o_count       = count_r;
    assign o_overflow    = overflow_r;

endmodule

// File: tb/tb_rv_fetch_queue.sv
// tb_rv_fetch_queue
//   Directed bench for rv_fetch_queue (DEPTH=4, XLEN=32). Accepted pushes are
//   queued as expected pops; a monitor compares the head whenever decode
//   takes it. Occupancy and flag checks follow each directed step.
module tb_rv_fetch_queue;

    logic        i_clk;
    logic        i_reset;
    logic        i_flush;
    logic        i_valid;
    logic [31:0] i_pc;
    logic [31:0] i_instruction;
    logic        o_in_ready;
    logic        o_valid;
    logic [31:0] o_pc;
    logic [31:0] o_instruction;
    logic        o_compressed;
    logic        i_ready;
    logic [2:0]  o_count;
    logic        o_overflow;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t exp_q[$];
    int   m_count;
    int   checks;
    int   errors;
    int   pops_seen;
    int   pops_expected;

    rv_fetch_queue #(
        .DEPTH (4),
        .XLEN  (32)
    ) dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_flush       (i_flush),
        .i_valid       (i_valid),
        .i_pc          (i_pc),
        .i_instruction (i_instruction),
        .o_in_ready    (o_in_ready),
        .o_valid       (o_valid),
        .o_pc          (o_pc),
        .o_instruction (o_instruction),
        .o_compressed  (o_compressed),
        .i_ready       (i_ready),
        .o_count       (o_count),
        .o_overflow    (o_overflow)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // One clock of stimulus. The bench's own occupancy model decides whether
    // the push is accepted and whether a pop happens.
    task automatic cyc(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic rdy, input logic fl, input logic rst);
        logic acc;
        logic pop;
        exp_t e;
        i_valid       = v;
        i_pc          = pc;
        i_instruction = ins;
        i_ready       = rdy;
        i_flush       = fl;
        i_reset       = rst;
        acc = v && (m_count != 4) && !fl && !rst;
        pop = (m_count != 0) && rdy && !fl && !rst;
        if (rst || fl) begin
            exp_q.delete();
            m_count = 0;
        end else begin
            if (acc) begin
                e.pc    = pc;
                e.instr = ins;
                exp_q.push_back(e);
            end
            m_count = m_count + (acc ? 1 : 0) - (pop ? 1 : 0);
            if (pop) pops_expected++;
        end
        @(posedge i_clk);
        #1;
    endtask

    // Monitor: a pop happens at the coming edge, so the head must match the
    // oldest expected entry.
    always @(negedge i_clk) begin
        if (o_valid && i_ready && !i_flush && !i_reset) begin
            pops_seen++;
            if (exp_q.size() == 0) begin
                check32("pop_unexpected", o_pc, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check32("pop_pc", o_pc, e.pc);
                check32("pop_instr", o_instruction, e.instr);
                check32("pop_compressed", {31'd0, o_compressed},
                        {31'd0, (e.instr[1:0] != 2'b11)});
            end
        end
    end

    logic [31:0] stream_ins [10];
    logic        stream_ok;

    initial begin
        checks = 0; errors = 0; m_count = 0; pops_seen = 0; pops_expected = 0;
        stream_ins = '{32'h0000_0013, 32'h00A0_0093, 32'h0000_4501, 32'h0010_0113,
                       32'h0020_0193, 32'h0030_0213, 32'h0000_4501, 32'h0040_0293,
                       32'h0050_0313, 32'h0060_0393};
        i_reset = 1'b1; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
        i_pc = 32'd0; i_instruction = 32'd0;

        // Reset state
        cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        check32("rst_count", {29'd0, o_count}, 32'd0);
        check32("rst_in_ready", {31'd0, o_in_ready}, 32'd1);
        check32("rst_valid", {31'd0, o_valid}, 32'd0);
        check32("rst_pc", o_pc, 32'd0);
        check32("rst_instr", o_instruction, 32'd0);
        check32("rst_compressed", {31'd0, o_compressed}, 32'd0);
        check32("rst_overflow", {31'd0, o_overflow}, 32'd0);

        // Three pushes, decode stalled
        cyc(1'b1, 32'h100, 32'h0000_0013, 1'b0, 1'b0, 1'b0);
        check32("no_bypass_valid", {31'd0, o_valid}, 32'd1);
        check32("one_count", {29'd0, o_count}, 32'd1);
        cyc(1'b1, 32'h104, 32'h00A0_0093, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h108, 32'h0000_4501, 1'b0, 1'b0, 1'b0);
        check32("three_count", {29'd0, o_count}, 32'd3);
        check32("three_head_pc", o_pc, 32'h100);
        check32("three_head_comp", {31'd0, o_compressed}, 32'd0);

        // Fill, then overflow
        cyc(1'b1, 32'h10C, 32'h0010_0113, 1'b0, 1'b0, 1'b0);
        check32("full_count", {29'd0, o_count}, 32'd4);
        check32("full_in_ready", {31'd0, o_in_ready}, 32'd0);
        check32("full_overflow_clear", {31'd0, o_overflow}, 32'd0);
        cyc(1'b1, 32'h110, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
        check32("ovf_flag", {31'd0, o_overflow}, 32'd1);
        check32("ovf_count", {29'd0, o_count}, 32'd4);
        check32("ovf_head_stable", o_pc, 32'h100);

        // Full with push and pop together: only the pop happens
        cyc(1'b1, 32'h114, 32'h0020_0193, 1'b1, 1'b0, 1'b0);
        check32("fullpp_count", {29'd0, o_count}, 32'd3);
        check32("fullpp_in_ready", {31'd0, o_in_ready}, 32'd1);
        cyc(1'b1, 32'h114, 32'h0020_0193, 1'b0, 1'b0, 1'b0);
        check32("refill_count", {29'd0, o_count}, 32'd4);
        check32("ovf_sticky", {31'd0, o_overflow}, 32'd1);

        // Drain, then pop while empty
        for (int k = 0; k < 4; k++) cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        check32("drain_count", {29'd0, o_count}, 32'd0);
        check32("drain_pc", o_pc, 32'd0);
        cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        check32("empty_pop_count", {29'd0, o_count}, 32'd0);
        check32("empty_pop_valid", {31'd0, o_valid}, 32'd0);

        // Flush with push and pop in the same cycle
        cyc(1'b1, 32'h200, 32'h0000_0013, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h204, 32'h0010_0093, 1'b0, 1'b0, 1'b0);
        check32("preflush_count", {29'd0, o_count}, 32'd2);
        cyc(1'b1, 32'h208, 32'h0020_0093, 1'b1, 1'b1, 1'b0);
        check32("flush_count", {29'd0, o_count}, 32'd0);
        check32("flush_valid", {31'd0, o_valid}, 32'd0);
        check32("flush_overflow", {31'd0, o_overflow}, 32'd0);
        check32("flush_pc", o_pc, 32'd0);

        // Streaming one push and one pop per cycle across pointer wrap
        stream_ok = 1'b1;
        for (int k = 0; k < 10; k++) begin
            cyc(1'b1, 32'h300 + 32'(4 * k), stream_ins[k], 1'b1, 1'b0, 1'b0);
            if (o_count > 3'd1) stream_ok = 1'b0;
        end
        check32("stream_count_le1", {31'd0, stream_ok}, 32'd1);
        cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        check32("stream_drained", {29'd0, o_count}, 32'd0);

        // Reset beats flush with entries queued
        cyc(1'b1, 32'h500, 32'h0000_0013, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h504, 32'h0000_0013, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h508, 32'h0000_0013, 1'b0, 1'b0, 1'b0);
        check32("prerst_count", {29'd0, o_count}, 32'd3);
        cyc(1'b1, 32'h50C, 32'h0000_0013, 1'b1, 1'b1, 1'b1);
        check32("midrst_count", {29'd0, o_count}, 32'd0);
        check32("midrst_in_ready", {31'd0, o_in_ready}, 32'd1);
        check32("midrst_instr", o_instruction, 32'd0);

        // Still functional after reset
        cyc(1'b1, 32'h600, 32'h0000_4501, 1'b0, 1'b0, 1'b0);
        check32("post_head_pc", o_pc, 32'h600);
        check32("post_head_comp", {31'd0, o_compressed}, 32'd1);
        cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);

        check32("scoreboard_empty", exp_q.size(), 32'd0);
        check32("pops_total", pops_seen, pops_expected);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv_fetch_queue.md
RV_FETCH_QUEUE -- requirements
Module: rv_fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of queue entries; power of two, 2..16.
REQ-002 SHALL have parameter XLEN, default 32, width of pc and instruction fields.
REQ-003 SHALL have port i_clk  input  1  single clock; all state on posedge.
REQ-004 SHALL have port i_reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port i_flush  input  1  redirect (pc_select); discard all entries.
REQ-006 SHALL have port i_valid  input  1  aligner output valid (aligner o_ready).
REQ-007 SHALL have port i_pc  input  XLEN  pc of incoming instruction.
REQ-008 SHALL have port i_instruction  input  XLEN  aligned instruction word.
REQ-009 SHALL have port o_in_ready  output  1  queue can accept a push this cycle.
REQ-010 SHALL have port o_valid  output  1  head entry valid toward decode.
REQ-011 SHALL have port o_pc  output  XLEN  head entry pc.
REQ-012 SHALL have port o_instruction  output  XLEN  head entry instruction.
REQ-013 SHALL have port o_compressed  output  1  head instruction[1:0] != 2'b11.
REQ-014 SHALL have port i_ready  input  1  decode accepts head this cycle.
REQ-015 SHALL have port o_count  output  $clog2(DEPTH)+1  current occupancy.
REQ-016 SHALL have port o_overflow  output  1  sticky: push attempted while full.

Function
REQ-017 Push SHALL occur when i_valid & o_in_ready & !i_flush; entry {i_pc, i_instruction} written at write pointer.
REQ-018 Pop SHALL occur when o_valid & i_ready & !i_flush; read pointer advances.
REQ-019 o_in_ready SHALL equal (o_count != DEPTH); no combinational path from i_ready.
REQ-020 o_valid SHALL equal (o_count != 0); no same-cycle bypass: a push becomes visible at the head one cycle later.
REQ-021 Simultaneous push and pop SHALL leave o_count unchanged and both pointers advance.
REQ-022 Pointers SHALL be $clog2(DEPTH) bits and wrap modulo DEPTH; occupancy kept in a separate counter.
REQ-023 When o_valid is 0, o_pc, o_instruction SHALL read 0 and o_compressed SHALL read 0.
REQ-024 i_flush SHALL, next cycle, give o_count=0, pointers=0, o_valid=0, and clear o_overflow; a push or pop in the flush cycle SHALL be ignored.
REQ-025 i_valid while full and not flushing SHALL drop the data, leave state unchanged, and set o_overflow until reset or flush.
REQ-026 i_ready while empty SHALL have no effect.
REQ-027 Head outputs SHALL remain stable while o_valid & !i_ready & !i_flush.

Reset
REQ-028 On i_reset SHALL set o_count=0, pointers=0, o_overflow=0, thus o_valid=0, o_in_ready=1, and o_pc/o_instruction/o_compressed=0.
REQ-029 i_reset SHALL take priority over i_flush, push and pop; reset mid-operation discards all entries.
REQ-030 Storage array SHALL need no reset; reads gated by REQ-023.

Structure
REQ-031 Typedef fetch_entry_t {pc, instruction} and constant FETCH_Q_DEPTH SHALL reside in shared package rv_fetch_pkg.
REQ-032 Storage SHALL be a sub-module rv_fetch_queue_mem (DEPTH x fetch_entry_t, 1 write port, 1 async read port); control logic stays in rv_fetch_queue.

Verification
REQ-033 Reset, then push pc 0x100/0x00000013, 0x104/0x00A00093, 0x108/0x4501 with i_ready=0 -> o_count=3, head pc 0x100, o_compressed=0.
REQ-034 Fill DEPTH=4, then push a fifth entry -> o_in_ready=0, o_overflow=1, count stays 4, pop order 0x100,0x104,0x108,0x10C.
REQ-035 Full queue, i_valid=1 and i_ready=1 in the same cycle -> push ignored (o_in_ready=0), pop occurs, count 3; next cycle push accepted, count 4.
REQ-036 Occupancy 2, assert i_flush with i_valid=1 and i_ready=1 -> next cycle o_count=0, o_valid=0, o_overflow=0, o_pc=0.
REQ-037 Stream 10 pushes and pops at 1/cycle through DEPTH=4 -> pointers wrap, order preserved, o_count never exceeds 1; 0x4501 head gives o_compressed=1.
REQ-038 Assert i_reset with 3 entries queued and i_flush=1 -> next cycle o_count=0, o_in_ready=1, o_instruction=0.
